// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle datapath control FSM: state codes,
// instruction fields, ALU operations and datapath select values.
package ctrl_pkg;

  // 17 states packed into a 5-bit register; codes 17..31 are unused.
  typedef enum logic [4:0] {
    ST_FETCH0    = 5'd0,
    ST_FETCH1    = 5'd1,
    ST_FETCH2    = 5'd2,
    ST_DECODE    = 5'd3,
    ST_EXEC_R    = 5'd4,
    ST_EXEC_I    = 5'd5,
    ST_ADDR      = 5'd6,
    ST_MEM0      = 5'd7,
    ST_MEM1      = 5'd8,
    ST_MEM2      = 5'd9,
    ST_ADDM_EXEC = 5'd10,
    ST_WB_ALU    = 5'd11,
    ST_WB_MEM    = 5'd12,
    ST_STORE     = 5'd13,
    ST_BRANCH    = 5'd14,
    ST_JUMP      = 5'd15,
    ST_ILLEGAL   = 5'd16
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_ADDM = 6'h05;

  // ALU operations
  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  // ALU source-A select
  localparam logic [1:0] ALU_SRC_A_ALUOUT = 2'b00;
  localparam logic [1:0] ALU_SRC_A_REGA   = 2'b01;
  localparam logic [1:0] ALU_SRC_A_PC     = 2'b10;
  localparam logic [1:0] ALU_SRC_A_MDR    = 2'b11;

  // ALU source-B select
  localparam logic [1:0] ALU_SRC_B_REGB    = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM     = 2'b10;
  localparam logic [1:0] ALU_SRC_B_IMM_SH2 = 2'b11;

  // Memory address select
  localparam logic [1:0] IORD_PC     = 2'b00;
  localparam logic [1:0] IORD_ALUOUT = 2'b01;
  localparam logic [1:0] IORD_REGA   = 2'b10;

  // PC source select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // addm is an R-type whose second operand comes from memory at RegA.
  function automatic logic is_addm(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_RTYPE) && (fn == FN_ADDM);
  endfunction

  function automatic logic is_rtype_arith(input logic [5:0] fn);
    return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND);
  endfunction

  // ALU operation for a register-register instruction.
  function automatic logic [2:0] rtype_alu_op(input logic [5:0] fn);
    logic [2:0] op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle datapath. Moore machine: every output
// is a decode of the current state, refined by opcode/funct where the
// instruction changes a select (iord for addm, reg_dst, R-type ALU op).
//
// state      | meaning
// -----------+----------------------------------------------------------
// FETCH0     | drive PC to memory, compute PC+4 (reset state)
// FETCH1     | memory read wait
// FETCH2     | latch IR, write PC+4
// DECODE     | latch RegA/RegB, precompute branch target into ALUOut
// EXEC_R     | register-register ALU operation
// EXEC_I     | RegA + immediate (addi)
// ADDR       | RegA + immediate effective address (lw/sw)
// MEM0       | memory address driven (ALUOut, or RegA for addm)
// MEM1       | memory read wait
// MEM2       | latch MDR
// ADDM_EXEC  | MDR + RegB
// WB_ALU     | write ALUOut to register file
// WB_MEM     | write MDR to register file
// STORE      | memory write at ALUOut
// BRANCH     | RegA - RegB, conditional PC write from ALUOut
// JUMP       | PC <= jump target
// ILLEGAL    | undecodable instruction, one-cycle flag
module multicycle_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [1:0] alu_src_a_control,
  output logic [1:0] alu_src_b_control,
  output logic [2:0] alu_op,
  output logic [1:0] iord,
  output logic [1:0] pc_source,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       mem_wr,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic       rega_wr,
  output logic       regb_wr,
  output logic       aluout_wr,
  output logic       mdr_wr,
  output logic       illegal_op,
  output logic [4:0] state_out
);

  state_e state_q, state_d;

  // zero is consumed by the datapath's PC-write gating, not here.
  logic unused_zero;
  assign unused_zero = zero;

  logic addm_c;
  assign addm_c = is_addm(opcode, funct);

  // State register; reset lands in FETCH0 whose decode has no write enables.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: instruction fields only matter in DECODE, ADDR and MEM2.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH0: state_d = ST_FETCH1;
      ST_FETCH1: state_d = ST_FETCH2;
      ST_FETCH2: state_d = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE: begin
            if (is_rtype_arith(funct)) begin
              state_d = ST_EXEC_R;
            end else if (funct == FN_ADDM) begin
              state_d = ST_MEM0;
            end else begin
              state_d = ST_ILLEGAL;
            end
          end
          OP_ADDI: state_d = ST_EXEC_I;
          OP_LW,
          OP_SW:   state_d = ST_ADDR;
          OP_BEQ:  state_d = ST_BRANCH;
          OP_J:    state_d = ST_JUMP;
          default: state_d = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R,
      ST_EXEC_I,
      ST_ADDM_EXEC: state_d = ST_WB_ALU;
      ST_ADDR: state_d = (opcode == OP_SW) ? ST_STORE : ST_MEM0;
      ST_MEM0: state_d = ST_MEM1;
      ST_MEM1: state_d = ST_MEM2;
      ST_MEM2: state_d = (opcode == OP_LW) ? ST_WB_MEM : ST_ADDM_EXEC;
      ST_WB_ALU,
      ST_WB_MEM,
      ST_STORE,
      ST_BRANCH,
      ST_JUMP,
      ST_ILLEGAL: state_d = ST_FETCH0;
      // Unused codes fall back to a clean fetch.
      default: state_d = ST_FETCH0;
    endcase
  end

  // Output decode: everything idle/00 unless the state asserts it.
  always_comb begin
    alu_src_a_control = ALU_SRC_A_ALUOUT;
    alu_src_b_control = ALU_SRC_B_REGB;
    alu_op            = ALU_PASS;
    iord              = IORD_PC;
    pc_source         = PC_SRC_ALU;
    reg_dst           = 1'b0;
    mem_to_reg        = 1'b0;
    pc_write          = 1'b0;
    pc_write_cond     = 1'b0;
    mem_wr            = 1'b0;
    ir_wr             = 1'b0;
    reg_wr            = 1'b0;
    rega_wr           = 1'b0;
    regb_wr           = 1'b0;
    aluout_wr         = 1'b0;
    mdr_wr            = 1'b0;
    illegal_op        = 1'b0;
    case (state_q)
      ST_FETCH0,
      ST_FETCH1: begin
        alu_src_a_control = ALU_SRC_A_PC;
        alu_src_b_control = ALU_SRC_B_FOUR;
        alu_op            = ALU_ADD;
        iord              = IORD_PC;
      end
      ST_FETCH2: begin
        alu_src_a_control = ALU_SRC_A_PC;
        alu_src_b_control = ALU_SRC_B_FOUR;
        alu_op            = ALU_ADD;
        iord              = IORD_PC;
        ir_wr             = 1'b1;
        pc_write          = 1'b1;
        pc_source         = PC_SRC_ALU;
      end
      ST_DECODE: begin
        rega_wr           = 1'b1;
        regb_wr           = 1'b1;
        alu_src_a_control = ALU_SRC_A_PC;
        alu_src_b_control = ALU_SRC_B_IMM_SH2;
        alu_op            = ALU_ADD;
        aluout_wr         = 1'b1;
      end
      ST_EXEC_R: begin
        alu_src_a_control = ALU_SRC_A_REGA;
        alu_src_b_control = ALU_SRC_B_REGB;
        alu_op            = rtype_alu_op(funct);
        aluout_wr         = 1'b1;
      end
      ST_EXEC_I,
      ST_ADDR: begin
        alu_src_a_control = ALU_SRC_A_REGA;
        alu_src_b_control = ALU_SRC_B_IMM;
        alu_op            = ALU_ADD;
        aluout_wr         = 1'b1;
      end
      ST_MEM0,
      ST_MEM1: begin
        iord = addm_c ? IORD_REGA : IORD_ALUOUT;
      end
      ST_MEM2: begin
        iord   = addm_c ? IORD_REGA : IORD_ALUOUT;
        mdr_wr = 1'b1;
      end
      ST_ADDM_EXEC: begin
        alu_src_a_control = ALU_SRC_A_MDR;
        alu_src_b_control = ALU_SRC_B_REGB;
        alu_op            = ALU_ADD;
        aluout_wr         = 1'b1;
      end
      ST_WB_ALU: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b0;
        reg_dst    = (opcode == OP_RTYPE);
      end
      ST_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        reg_dst    = 1'b0;
      end
      ST_STORE: begin
        iord   = IORD_ALUOUT;
        mem_wr = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a_control = ALU_SRC_A_REGA;
        alu_src_b_control = ALU_SRC_B_REGB;
        alu_op            = ALU_SUB;
        pc_source         = PC_SRC_ALUOUT;
        pc_write_cond     = 1'b1;
      end
      ST_JUMP: begin
        pc_source = PC_SRC_JUMP;
        pc_write  = 1'b1;
      end
      ST_ILLEGAL: begin
        illegal_op = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign state_out = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each instruction is expanded into a list of
// per-cycle expected control words built from the instruction's phase
// table; one compare process checks the DUT against that list mid-cycle.
module tb_multicycle_ctrl;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic       zero = 1'b0;
  logic [1:0] alu_src_a_control, alu_src_b_control, iord, pc_source;
  logic [2:0] alu_op;
  logic       reg_dst, mem_to_reg;
  logic       pc_write, pc_write_cond, mem_wr, ir_wr, reg_wr;
  logic       rega_wr, regb_wr, aluout_wr, mdr_wr, illegal_op;
  logic [4:0] state_out;

  multicycle_ctrl dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .alu_src_a_control(alu_src_a_control), .alu_src_b_control(alu_src_b_control),
    .alu_op(alu_op), .iord(iord), .pc_source(pc_source), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .mem_wr(mem_wr), .ir_wr(ir_wr), .reg_wr(reg_wr), .rega_wr(rega_wr),
    .regb_wr(regb_wr), .aluout_wr(aluout_wr), .mdr_wr(mdr_wr),
    .illegal_op(illegal_op), .state_out(state_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] st;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] op;
    logic [1:0] io;
    logic [1:0] ps;
    logic       rd;
    logic       m2;
    logic [9:0] en;
  } rec_t;

  localparam logic [9:0] EN_PCW = 10'h200, EN_PWC = 10'h100, EN_MW  = 10'h080,
                         EN_IR  = 10'h040, EN_RW  = 10'h020, EN_RA  = 10'h010,
                         EN_RB  = 10'h008, EN_AO  = 10'h004, EN_MDR = 10'h002,
                         EN_ILL = 10'h001;

  rec_t  exp_q[$];
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  string cur_name = "reset";

  function automatic logic [9:0] dut_en();
    return {pc_write, pc_write_cond, mem_wr, ir_wr, reg_wr,
            rega_wr, regb_wr, aluout_wr, mdr_wr, illegal_op};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] st, input logic [1:0] a, input logic [1:0] b,
                      input logic [2:0] op, input logic [1:0] io, input logic [1:0] ps,
                      input logic rd, input logic m2, input logic [9:0] en);
    rec_t r;
    r = {st, a, b, op, io, ps, rd, m2, en};
    exp_q.push_back(r);
  endtask

  // Phase table of one instruction, from FETCH0 through its last state.
  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] rop;
    push(ST_FETCH0, 2'b10, 2'b01, 3'b001, 2'b00, 2'b00, 0, 0, 10'h0);
    push(ST_FETCH1, 2'b10, 2'b01, 3'b001, 2'b00, 2'b00, 0, 0, 10'h0);
    push(ST_FETCH2, 2'b10, 2'b01, 3'b001, 2'b00, 2'b00, 0, 0, EN_IR | EN_PCW);
    push(ST_DECODE, 2'b10, 2'b11, 3'b001, 2'b00, 2'b00, 0, 0, EN_RA | EN_RB | EN_AO);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
      rop = (fn == 6'h22) ? 3'b010 : (fn == 6'h24) ? 3'b011 : 3'b001;
      push(ST_EXEC_R, 2'b01, 2'b00, rop, 2'b00, 2'b00, 0, 0, EN_AO);
      push(ST_WB_ALU, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0, EN_RW);
    end else if (op == 6'h00 && fn == 6'h05) begin
      push(ST_MEM0, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00, 0, 0, 10'h0);
      push(ST_MEM1, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00, 0, 0, 10'h0);
      push(ST_MEM2, 2'b00, 2'b00, 3'b000, 2'b10, 2'b00, 0, 0, EN_MDR);
      push(ST_ADDM_EXEC, 2'b11, 2'b00, 3'b001, 2'b00, 2'b00, 0, 0, EN_AO);
      push(ST_WB_ALU, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0, EN_RW);
    end else if (op == 6'h08) begin
      push(ST_EXEC_I, 2'b01, 2'b10, 3'b001, 2'b00, 2'b00, 0, 0, EN_AO);
      push(ST_WB_ALU, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, EN_RW);
    end else if (op == 6'h23) begin
      push(ST_ADDR, 2'b01, 2'b10, 3'b001, 2'b00, 2'b00, 0, 0, EN_AO);
      push(ST_MEM0, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0, 0, 10'h0);
      push(ST_MEM1, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0, 0, 10'h0);
      push(ST_MEM2, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0, 0, EN_MDR);
      push(ST_WB_MEM, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 1, EN_RW);
    end else if (op == 6'h2B) begin
      push(ST_ADDR, 2'b01, 2'b10, 3'b001, 2'b00, 2'b00, 0, 0, EN_AO);
      push(ST_STORE, 2'b00, 2'b00, 3'b000, 2'b01, 2'b00, 0, 0, EN_MW);
    end else if (op == 6'h04) begin
      push(ST_BRANCH, 2'b01, 2'b00, 3'b010, 2'b00, 2'b01, 0, 0, EN_PWC);
    end else if (op == 6'h02) begin
      push(ST_JUMP, 2'b00, 2'b00, 3'b000, 2'b00, 2'b10, 0, 0, EN_PCW);
    end else begin
      push(ST_ILLEGAL, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0, EN_ILL);
    end
  endtask

  // Compare process: mid-cycle, one expected control word per cycle.
  always @(negedge clk) begin
    rec_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state_out, alu_src_a_control, alu_src_b_control, alu_op, iord, pc_source,
           reg_dst, mem_to_reg, dut_en()};
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got st=%0d a=%b b=%b op=%b io=%b ps=%b rd=%b m2=%b en=%b expected st=%0d a=%b b=%b op=%b io=%b ps=%b rd=%b m2=%b en=%b",
                 cur_name, cyc, a.st, a.a, a.b, a.op, a.io, a.ps, a.rd, a.m2, a.en,
                 e.st, e.a, e.b, e.op, e.io, e.ps, e.rd, e.m2, e.en);
      end
    end
  end

  // Hold reset for n cycles, then release just after a rising edge.
  task automatic do_reset(input int n);
    reset_n = 1'b0;
    #1;
    check("reset_async_state", 32'(state_out), 32'd0);
    check("reset_no_enables", 32'(dut_en()), 32'd0);
    for (int i = 0; i < n; i++)
      push(ST_FETCH0, 2'b10, 2'b01, 3'b001, 2'b00, 2'b00, 0, 0, 10'h0);
    repeat (n) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Called just after the rising edge that enters FETCH0.
  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int lat);
    int n;
    cur_name = nm;
    opcode = op;
    funct = fn;
    zero = z;
    build(op, fn);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (n == 2) begin
        check({nm, "_f2_ir_wr"}, 32'(ir_wr), 32'd1);
        check({nm, "_f2_pc_write"}, 32'(pc_write), 32'd1);
        check({nm, "_f2_src_a"}, 32'(alu_src_a_control), 32'd2);
      end
    end while (state_out != 5'd0 && n < 20);
    check({nm, "_latency"}, 32'(n), 32'(lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b1;
    #2;
    do_reset(3);

    run_instr("add",  6'h00, 6'h20, 1'b0, 6);
    run_instr("sub",  6'h00, 6'h22, 1'b0, 6);
    run_instr("and",  6'h00, 6'h24, 1'b1, 6);
    run_instr("addi", 6'h08, 6'h3F, 1'b0, 6);
    run_instr("lw",   6'h23, 6'h05, 1'b0, 9);
    run_instr("sw",   6'h2B, 6'h00, 1'b0, 6);
    run_instr("addm", 6'h00, 6'h05, 1'b0, 9);
    run_instr("beq_z1", 6'h04, 6'h00, 1'b1, 5);
    run_instr("beq_z0", 6'h04, 6'h00, 1'b0, 5);
    run_instr("j",    6'h02, 6'h20, 1'b0, 5);
    run_instr("ill_op", 6'h3F, 6'h20, 1'b0, 5);
    run_instr("ill_funct", 6'h00, 6'h2A, 1'b0, 5);

    // lw interrupted by reset while in MEM1 (six edges after FETCH0).
    cur_name = "lw_reset";
    opcode = 6'h23;
    funct = 6'h00;
    build(6'h23, 6'h00);
    repeat (6) @(posedge clk);
    #1;
    check("lw_reset_in_mem1_iord", 32'(iord), 32'd1);
    check("lw_reset_mdr_before", 32'(mdr_wr), 32'd0);
    exp_q.delete();
    do_reset(2);

    run_instr("sw_after_reset", 6'h2B, 6'h00, 1'b0, 6);
    run_instr("add_final", 6'h00, 6'h20, 1'b0, 6);

    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
